// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA job controller and its
// Montgomery-constant generator.
package rsa_pkg;

   localparam int OP_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CONST = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_MOD     = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   // Montgomery arithmetic needs an odd modulus of at least 3.
   function automatic logic bad_modulus(input logic [OP_W-1:0] m);
      return (m[0] == 1'b0) || (m < OP_W'(3));
   endfunction

endpackage

// File: rtl/rsa_const_gen.sv
// Computes 2^(2*R_EXP) mod m by repeated modular doubling, one step per cycle.
// c/done are combinational and present the final step's result in its own cycle.
module rsa_const_gen
   import rsa_pkg::*;
#(
   parameter int R_EXP = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [OP_W-1:0] m,
   output logic            busy,
   output logic            done,
   output logic [OP_W-1:0] c
);

   localparam int ITERS = 2 * R_EXP;
   localparam int CW    = $clog2(ITERS + 1);

   logic [OP_W-1:0] c_q, c_d, c_nxt;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic [OP_W:0]   dbl;

   always_comb begin
      dbl   = {c_q, 1'b0};
      // c < m always holds, so one conditional subtract keeps the result below m.
      c_nxt = (dbl >= {1'b0, m}) ? OP_W'(dbl - {1'b0, m}) : dbl[OP_W-1:0];
      done  = busy_q && (cnt_q == CW'(ITERS - 1));
      c     = c_nxt;
      busy  = busy_q;

      c_d    = c_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (start) begin
         c_d    = OP_W'(1);
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         c_d   = c_nxt;
         cnt_d = cnt_q + CW'(1);
         if (done) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         c_q    <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         c_q    <= c_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/rsa_job_ctrl.sv
// Job-level initiator for the 8-bit RSA unit: accepts a job, derives the
// Montgomery constant, runs the unit with a timeout and returns the result.
module rsa_job_ctrl
   import rsa_pkg::*;
#(
   parameter int R_EXP          = 10,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OP_W-1:0] in_m,
   input  logic [OP_W-1:0] in_e,
   input  logic [OP_W-1:0] in_p,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [OP_W-1:0] out_c,
   output logic [1:0]      out_err,
   output logic            rsa_en,
   output logic [OP_W-1:0] rsa_m,
   output logic [OP_W-1:0] rsa_e,
   output logic [OP_W-1:0] rsa_p,
   output logic [OP_W-1:0] rsa_const,
   input  logic            rsa_eoc,
   input  logic [OP_W-1:0] rsa_c
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   state_e          state_q, state_d;
   logic [OP_W-1:0] m_q, m_d, e_q, e_d, p_q, p_d, const_q, const_d, c_q, c_d;
   logic [1:0]      err_q, err_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic            cg_start, cg_busy, cg_done;
   logic [OP_W-1:0] cg_c;

   rsa_const_gen #(.R_EXP(R_EXP)) u_const_gen (
      .clk   (clk),
      .rst   (rst),
      .start (cg_start),
      .m     (m_q),
      .busy  (cg_busy),
      .done  (cg_done),
      .c     (cg_c)
   );

   always_comb begin
      state_d  = state_q;
      m_d      = m_q;
      e_d      = e_q;
      p_d      = p_q;
      const_d  = const_q;
      c_d      = c_q;
      err_d    = err_q;
      tcnt_d   = tcnt_q;
      cg_start = 1'b0;
      in_ready = (state_q == ST_IDLE) && !cg_busy;

      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               m_d = in_m;
               e_d = in_e;
               p_d = in_p;
               if (bad_modulus(in_m)) begin
                  c_d     = '0;
                  err_d   = ERR_MOD;
                  state_d = ST_DONE;
               end else begin
                  cg_start = 1'b1;
                  state_d  = ST_CONST;
               end
            end
         end
         ST_CONST: begin
            if (cg_done) begin
               const_d = cg_c;
               tcnt_d  = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            tcnt_d = tcnt_q + TW'(1);
            // eoc takes priority over a timeout expiring in the same cycle.
            if (rsa_eoc) begin
               c_d     = rsa_c;
               err_d   = ERR_OK;
               state_d = ST_DONE;
            end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
               c_d     = '0;
               err_d   = ERR_TIMEOUT;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         m_q     <= '0;
         e_q     <= '0;
         p_q     <= '0;
         const_q <= '0;
         c_q     <= '0;
         err_q   <= ERR_OK;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         e_q     <= e_d;
         p_q     <= p_d;
         const_q <= const_d;
         c_q     <= c_d;
         err_q   <= err_d;
         tcnt_q  <= tcnt_d;
      end
   end

   assign out_valid = (state_q == ST_DONE);
   assign out_c     = c_q;
   assign out_err   = err_q;
   assign rsa_en    = (state_q == ST_RUN);
   assign rsa_m     = m_q;
   assign rsa_e     = e_q;
   assign rsa_p     = p_q;
   assign rsa_const = const_q;

endmodule

// File: tb/tb_rsa_job_ctrl.sv
// Directed bench for rsa_job_ctrl with a simple RSA-unit model raising eoc
// a fixed number of cycles after en.
module tb_rsa_job_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready;
   logic [7:0] in_m, in_e, in_p;
   logic       out_valid, out_ready;
   logic [7:0] out_c;
   logic [1:0] out_err;
   logic       rsa_en, rsa_eoc;
   logic [7:0] rsa_m, rsa_e, rsa_p, rsa_const, rsa_c;

   int   vectors = 0;
   int   miscompares = 0;
   logic eoc_en = 1'b0;
   logic eoc_force = 1'b0;
   int   eoc_lat = 50;
   int   en_cnt = 0;
   logic [7:0] model_c = 8'd0;
   int   n;

   always #5 clk = ~clk;

   rsa_job_ctrl #(.R_EXP(10), .TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_m(in_m), .in_e(in_e), .in_p(in_p),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_c(out_c), .out_err(out_err),
      .rsa_en(rsa_en), .rsa_m(rsa_m), .rsa_e(rsa_e), .rsa_p(rsa_p),
      .rsa_const(rsa_const), .rsa_eoc(rsa_eoc), .rsa_c(rsa_c)
   );

   always @(posedge clk) en_cnt <= rsa_en ? en_cnt + 1 : 0;
   assign rsa_eoc = eoc_force | (eoc_en && rsa_en && (en_cnt == eoc_lat - 1));
   assign rsa_c   = model_c;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic submit(input logic [7:0] m, input logic [7:0] e, input logic [7:0] p);
      in_valid = 1'b1; in_m = m; in_e = e; in_p = p;
      tick();
      in_valid = 1'b0;
   endtask

   // Returns edges since acceptance until rsa_en is seen (acceptance edge counts as 1).
   task automatic wait_en(output int lat);
      lat = 1;
      while (!rsa_en && lat < 200) begin tick(); lat++; end
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 300) begin tick(); cyc++; end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
      chk("post_hs_ready", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_m = '0; in_e = '0; in_p = '0; out_ready = 1'b0;
      tick(); tick();
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_c",     {24'd0, out_c},     32'd0);
      chk("rst_out_err",   {30'd0, out_err},   32'd0);
      chk("rst_rsa_en",    {31'd0, rsa_en},    32'd0);
      chk("rst_operands",  {rsa_m, rsa_e, rsa_p, rsa_const}, 32'd0);
      rst = 1'b0;
      tick();

      // Job A: M=33 -> const 1, result 29, en high 50 cycles.
      eoc_en = 1'b1; eoc_lat = 50; model_c = 8'd29;
      submit(8'd33, 8'd7, 8'd2);
      chk("A_busy_ready", {31'd0, in_ready}, 32'd0);
      wait_en(n);
      chk("A_en_latency", n, 32'd21);
      chk("A_const", {24'd0, rsa_const}, 32'd1);
      chk("A_ops", {8'd0, rsa_m, rsa_e, rsa_p}, {8'd0, 8'd33, 8'd7, 8'd2});
      n = 0;
      while (rsa_en && n < 200) begin tick(); n++; end
      chk("A_en_len", n, 32'd50);
      chk("A_valid", {31'd0, out_valid}, 32'd1);
      chk("A_out_c", {24'd0, out_c}, 32'd29);
      chk("A_err",   {30'd0, out_err}, 32'd0);
      handshake();

      // Job B: M=187 -> const 67, result 11; then hold result with out_ready low.
      model_c = 8'd11;
      submit(8'd187, 8'd7, 8'd88);
      wait_en(n);
      chk("B_en_latency", n, 32'd21);
      chk("B_const", {24'd0, rsa_const}, 32'd67);
      wait_valid(n);
      chk("B_valid", {31'd0, out_valid}, 32'd1);
      chk("B_out_c", {24'd0, out_c}, 32'd11);
      chk("B_err",   {30'd0, out_err}, 32'd0);
      in_valid = 1'b1; in_m = 8'd33; in_e = 8'd7; in_p = 8'd2;
      for (int i = 0; i < 5; i++) begin
         eoc_force = ~eoc_force;
         tick();
         chk("hold_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_out",   {22'd0, out_err, out_c}, {22'd0, 2'd0, 8'd11});
         chk("hold_ready", {31'd0, in_ready}, 32'd0);
         chk("hold_en",    {31'd0, rsa_en}, 32'd0);
      end
      eoc_force = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("hold_hs_valid", {31'd0, out_valid}, 32'd0);
      chk("hold_hs_ready", {31'd0, in_ready}, 32'd1);
      chk("hold_no_reaccept", {24'd0, rsa_m}, 32'd187);

      // Timeout job, accepted one cycle after the handshake.
      eoc_en = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("T_accept", {24'd0, rsa_m}, 32'd33);
      wait_en(n);
      chk("T_en_latency", n, 32'd21);
      wait_valid(n);
      chk("T_cycles", n, 32'd64);
      chk("T_err",   {30'd0, out_err}, 32'd2);
      chk("T_out_c", {24'd0, out_c}, 32'd0);
      chk("T_en_low", {31'd0, rsa_en}, 32'd0);
      handshake();

      // Bad moduli: even, and below 3.
      submit(8'd34, 8'd7, 8'd2);
      chk("M34_valid", {31'd0, out_valid}, 32'd1);
      chk("M34_err",   {30'd0, out_err}, 32'd1);
      chk("M34_en",    {31'd0, rsa_en}, 32'd0);
      handshake();
      submit(8'd1, 8'd7, 8'd2);
      chk("M1_valid", {31'd0, out_valid}, 32'd1);
      chk("M1_err",   {30'd0, out_err}, 32'd1);
      chk("M1_out_c", {24'd0, out_c}, 32'd0);
      chk("M1_en",    {31'd0, rsa_en}, 32'd0);
      handshake();

      // Reset during RUN aborts the job.
      eoc_en = 1'b1; model_c = 8'd11;
      submit(8'd187, 8'd7, 8'd88);
      wait_en(n);
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("R_en",    {31'd0, rsa_en}, 32'd0);
      chk("R_valid", {31'd0, out_valid}, 32'd0);
      chk("R_ready", {31'd0, in_ready}, 32'd1);
      model_c = 8'd29;
      submit(8'd33, 8'd7, 8'd2);
      wait_valid(n);
      chk("R_job_valid", {31'd0, out_valid}, 32'd1);
      chk("R_job_out_c", {24'd0, out_c}, 32'd29);
      chk("R_job_err",   {30'd0, out_err}, 32'd0);
      handshake();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rsa_job_ctrl.md
# rsa_job_ctrl

Job-level initiator for the 8-bit RSA modular-exponentiation unit. It accepts one job (modulus M, exponent E, plaintext P) per valid/ready handshake and computes the Montgomery constant Const = 2^(2·R_EXP) mod M on-chip, so the host never precomputes it. It then drives the RSA unit's `en`/`eoc` protocol, captures the result C and returns it through a second valid/ready handshake. The block sits between the host/register interface and the RSA unit and is the only agent that toggles the unit's `en`.

## Interface
- `R_EXP`, default 10: Montgomery radix exponent; must match the unit's internal datapath width.
- `TIMEOUT_CYCLES`, default 4096: maximum cycles to wait for `rsa_eoc` before aborting.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: job offered.
- `in_ready` out 1: block idle and able to accept a job.
- `in_m` in 8: modulus M.
- `in_e` in 8: exponent E.
- `in_p` in 8: plaintext P.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes result.
- `out_c` out 8: ciphertext C.
- `out_err` out 2: 0 = ok, 1 = bad modulus, 2 = timeout.
- `rsa_en` out 1: enable to RSA unit.
- `rsa_m`, `rsa_e`, `rsa_p`, `rsa_const` out 8 each: operands to RSA unit, stable while `rsa_en`=1.
- `rsa_eoc` in 1: end-of-conversion from RSA unit.
- `rsa_c` in 8: result from RSA unit, valid when `rsa_eoc`=1.

## Operation
- States: IDLE, CONST, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, latch M/E/P into operand registers.
  - M even or M<3: go to DONE with `out_err`=1 and `out_c`=0.
  - Otherwise: go to CONST with accumulator c=1 and counter=0.
- CONST: run 2·R_EXP iterations, one per cycle.
  - Each iteration computes c = 2c, then subtracts M if the doubled value ≥ M.
  - The doubled value is 9 bits wide; c is always < M and fits in 8 bits.
  - After the last iteration, load `rsa_const` = c and go to RUN.
- RUN: `rsa_en`=1 and the timeout counter increments each cycle.
  - On the first cycle with `rsa_eoc`=1: capture `rsa_c` into `out_c`, set `out_err`=0, go to DONE.
  - If the counter reaches TIMEOUT_CYCLES first: set `out_c`=0, `out_err`=2, go to DONE.
- DONE: `rsa_en`=0 and `out_valid`=1. `out_c`/`out_err` are held stable until `out_ready`=1, then go to IDLE.
- Because DONE lasts at least 1 cycle, `rsa_en` is low for at least one cycle between jobs. The RSA unit uses this gap to return to its idle state.
- `rsa_eoc` is ignored outside RUN.
- `in_valid` is ignored outside IDLE; `in_ready`=0 in CONST, RUN and DONE.
- If `rsa_eoc` and the timeout coincide in the same cycle, `rsa_eoc` wins (err 0).
- Operand outputs always reflect the latched registers and change only on job acceptance.

## Timing
- Reset values: IDLE, `in_ready`=1, `out_valid`=0, `out_c`=0, `out_err`=0, `rsa_en`=0, all `rsa_*` operands 0, counters 0.
- `rst` asserted mid-job drops `rsa_en` and aborts the job at the next edge; no result is produced.
- Acceptance at edge T:
  - CONST occupies T+1 .. T+2·R_EXP.
  - `rsa_en`=1 from T+2·R_EXP+1.
- `rsa_eoc` sampled high at edge X: `out_valid`=1 and `rsa_en`=0 from X+1.
- Bad modulus accepted at T: `out_valid`=1 from T+1.
- Result handshake completes on the edge where `out_valid && out_ready`. `in_ready`=1 from the next cycle, so there is no same-cycle re-accept.
- Timeout: `out_valid` rises exactly TIMEOUT_CYCLES cycles after `rsa_en` rises.

## Structure
- Shared package `rsa_pkg`:
  - state enum (IDLE/CONST/RUN/DONE);
  - error-code constants ERR_OK/ERR_MOD/ERR_TIMEOUT;
  - operand width constant (8).
- Sub-module `rsa_const_gen` computes 2^(2·R_EXP) mod M.
  - Ports: `start`, `m`, `busy`, `done`, `c`.
  - The parent FSM waits on `done`.
- Top-level FSM, timeout counter and operand/result registers stay in `rsa_job_ctrl`.

## Test plan
- M=33, E=7, P=2; RSA model raises `eoc` 50 cycles after `en` → `rsa_const`=1, `out_c`=29, `out_err`=0; `rsa_en` high for exactly 50 cycles.
- M=187, E=7, P=88 → `rsa_const`=67, `out_c`=11, `out_err`=0; `rsa_en` rises 21 cycles after acceptance.
- M=34, then M=1 → `out_valid` the cycle after acceptance, `out_err`=1, `out_c`=0, `rsa_en` never asserted.
- Model never raises `eoc`, TIMEOUT_CYCLES=64 → `out_err`=2, `out_c`=0 exactly 64 cycles after `rsa_en` rises; `rsa_en` low thereafter.
- Hold `out_ready`=0 for 5 cycles after a valid result, with `in_valid`=1 and `rsa_eoc` pulsing throughout → `out_c`/`out_err` stable, `in_ready`=0, state unchanged; after the handshake the next job is accepted no earlier than one cycle later.
- Assert `rst` for 1 cycle during RUN → next cycle `rsa_en`=0, `out_valid`=0, `in_ready`=1; a following M=33/E=7/P=2 job returns 29.
